// File: rtl/bcd_adder_display_if.sv
// Operand/result bundle between the switch/key front end and the BCD adder display block.
interface bcd_adder_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [WIDTH:0]        sum_bin;
    logic                  overflow;
    logic [7*DIGITS-1:0]   hex;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum_bin, overflow, hex
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum_bin, overflow, hex
    );
endinterface

// File: rtl/bcd_adder_display.sv
// Adds two unsigned operands plus carry-in, converts the sum to BCD one bit per clock
// (shift-add-3) and drives DIGITS active-low seven-segment fields from registered outputs.
module bcd_adder_display #(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter int LEAD_BLANK = 1
) (
    input logic               clk,
    input logic               rst,
    bcd_adder_display_if.slave bus
);
    localparam int SW    = WIDTH + 1;
    localparam int BW    = 4 * DIGITS;
    localparam int HW    = 7 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 2);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    logic [SW-1:0]     shreg;
    logic [SW-1:0]     sum_reg;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [CNT_W-1:0]  cnt;
    logic              lost;
    logic              fin_ovf;

    logic              busy_r;
    logic              done_r;
    logic [SW-1:0]     sum_bin_r;
    logic              overflow_r;
    logic [HW-1:0]     hex_r;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (r[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic bad_nibble(input logic [BW-1:0] v);
        logic r;
        r = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9)
                r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'b0000001;
            4'd1:    r = 7'b1001111;
            4'd2:    r = 7'b0010010;
            4'd3:    r = 7'b0000110;
            4'd4:    r = 7'b1001100;
            4'd5:    r = 7'b0100100;
            4'd6:    r = 7'b0100000;
            4'd7:    r = 7'b0001111;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0000100;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

    // Walk from the most significant digit down so "all higher digits zero" is a running AND.
    function automatic logic [HW-1:0] render(input logic [BW-1:0] v, input logic ovf);
        logic [HW-1:0] r;
        logic          lead;
        r    = '1;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && (v[4*k +: 4] == 4'd0);
            if (ovf)
                r[7*k +: 7] = SEG_DASH;
            else if ((LEAD_BLANK != 0) && lead && (k != 0))
                r[7*k +: 7] = SEG_BLANK;
            else
                r[7*k +: 7] = seg(v[4*k +: 4]);
        end
        return r;
    endfunction

    always_comb begin
        bcd_adj = add3(bcd);
        fin_ovf = lost | bad_nibble(bcd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            sum_reg    <= '0;
            bcd        <= '0;
            cnt        <= '0;
            lost       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sum_bin_r  <= '0;
            overflow_r <= 1'b0;
            hex_r      <= render('0, 1'b0);
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sum_reg <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                        shreg   <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                        bcd     <= '0;
                        lost    <= 1'b0;
                        cnt     <= CNT_W'(WIDTH + 1);
                        busy_r  <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    // A 1 leaving the top nibble means the value needs more than DIGITS digits.
                    {bcd, shreg} <= {bcd_adj[BW-2:0], shreg, 1'b0};
                    lost         <= lost | bcd_adj[BW-1];
                    cnt          <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    sum_bin_r  <= sum_reg;
                    overflow_r <= fin_ovf;
                    hex_r      <= render(bcd, fin_ovf);
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum_bin  = sum_bin_r;
    assign bus.overflow = overflow_r;
    assign bus.hex      = hex_r;
endmodule
